// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter and the CPU control unit:
// cpustate encodings, arbiter FSM states and default bus widths.
package mem_arbiter_pkg;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    CS_IDLE  = 2'b00,
    CS_IN    = 2'b01,
    CS_CHECK = 2'b10,
    CS_RUN   = 2'b11
  } cpustate_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACC_CPU,
    ST_ACC_HOST,
    ST_DONE_CPU,
    ST_DONE_HOST
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between CPU port, host loader/monitor port, memory and the arbiter.
// slave = arbiter side, master = requesters/memory side.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);
  cpustate_e         cpustate;
  logic              cpu_req;
  logic              cpu_we;
  logic [AW-1:0]     cpu_addr;
  logic [DW-1:0]     cpu_wdata;
  logic              cpu_ack;
  logic [DW-1:0]     cpu_rdata;
  logic              host_req;
  logic              host_we;
  logic [AW-1:0]     host_addr;
  logic [DW-1:0]     host_wdata;
  logic              host_ack;
  logic [DW-1:0]     host_rdata;
  logic              mem_cs;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata;

  modport slave (
    input  cpustate,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  host_req, host_we, host_addr, host_wdata,
    output host_ack, host_rdata,
    output mem_cs, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpustate,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output host_req, host_we, host_addr, host_wdata,
    input  host_ack, host_rdata,
    input  mem_cs, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arb_pick.sv
// Combinational grant selector: cpustate eligibility plus 1-bit round-robin tie break.
// MEM_ARB_RR_EN additionally makes the CPU eligible in CHECK mode (shared mode).
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  cpustate_e cpustate_i,
  input  logic      cpu_req_i,
  input  logic      host_req_i,
  input  logic      last_host_i,
  output logic      grant_cpu_o,
  output logic      grant_host_o
);

  logic cpu_elig;
  logic host_elig;
  logic cpu_want;
  logic host_want;

  always_comb begin
    host_elig = (cpustate_i == CS_IN) || (cpustate_i == CS_CHECK);
`ifdef MEM_ARB_RR_EN
    cpu_elig  = (cpustate_i == CS_RUN) || (cpustate_i == CS_CHECK);
`else
    cpu_elig  = (cpustate_i == CS_RUN);
`endif
    cpu_want  = cpu_req_i && cpu_elig;
    host_want = host_req_i && host_elig;
    // On a tie the port that did not win last time is served.
    grant_cpu_o  = cpu_want && (!host_want || last_host_i);
    grant_host_o = host_want && (!cpu_want || !last_host_i);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (CPU / host) arbiter onto a single synchronous memory, 3-cycle access.
// Optional shared CHECK-mode round-robin enabled by macro MEM_ARB_RR_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
)(
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  arb_state_e    state_q, state_d;
  logic          mem_cs_q, mem_cs_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          host_ack_q, host_ack_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] host_rdata_q, host_rdata_d;
  logic          last_host_q, last_host_d;
  logic          grant_cpu;
  logic          grant_host;

  mem_arb_pick u_pick (
    .cpustate_i   (bus.cpustate),
    .cpu_req_i    (bus.cpu_req),
    .host_req_i   (bus.host_req),
    .last_host_i  (last_host_q),
    .grant_cpu_o  (grant_cpu),
    .grant_host_o (grant_host)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_cs_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_ack_q    <= 1'b0;
      host_ack_q   <= 1'b0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
      last_host_q  <= 1'b0;
    end else begin
      mem_cs_q     <= mem_cs_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_ack_q    <= cpu_ack_d;
      host_ack_q   <= host_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
      host_rdata_q <= host_rdata_d;
      last_host_q  <= last_host_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_cs_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_ack_d    = 1'b0;
    host_ack_d   = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    host_rdata_d = host_rdata_q;
    last_host_d  = last_host_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_cpu) begin
          state_d     = ST_ACC_CPU;
          mem_cs_d    = 1'b1;
          mem_we_d    = bus.cpu_we;
          mem_addr_d  = bus.cpu_addr;
          mem_wdata_d = bus.cpu_wdata;
          last_host_d = 1'b0;
        end else if (grant_host) begin
          state_d     = ST_ACC_HOST;
          mem_cs_d    = 1'b1;
          mem_we_d    = bus.host_we;
          mem_addr_d  = bus.host_addr;
          mem_wdata_d = bus.host_wdata;
          last_host_d = 1'b1;
        end
      end
      // Read data is taken as the access cycle closes; writes keep old rdata.
      ST_ACC_CPU: begin
        state_d   = ST_DONE_CPU;
        cpu_ack_d = 1'b1;
        if (!mem_we_q) cpu_rdata_d = bus.mem_rdata;
      end
      ST_ACC_HOST: begin
        state_d    = ST_DONE_HOST;
        host_ack_d = 1'b1;
        if (!mem_we_q) host_rdata_d = bus.mem_rdata;
      end
      ST_DONE_CPU:  state_d = ST_IDLE;
      ST_DONE_HOST: state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  assign bus.mem_cs     = mem_cs_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.cpu_ack    = cpu_ack_q;
  assign bus.host_ack   = host_ack_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.host_rdata = host_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected memory accesses and acks are queued
// at stimulus time and popped by a negedge monitor. Honours MEM_ARB_RR_EN.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW = 16;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: written locations remembered, others return a fixed pattern.
  logic [DW-1:0] mdl_mem [256];
  bit            mdl_vld [256];

  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return a[7:0] ^ 8'h4A;
  endfunction

  assign bus.mem_rdata = mdl_vld[bus.mem_addr[7:0]] ? mdl_mem[bus.mem_addr[7:0]] : dflt(bus.mem_addr);

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) mdl_vld[i] <= 1'b0;
    end else if (bus.mem_cs && bus.mem_we) begin
      mdl_mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
      mdl_vld[bus.mem_addr[7:0]] <= 1'b1;
    end
  end

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_item_t;

  typedef struct {
    logic          host;
    logic [DW-1:0] rdata;
  } ack_item_t;

  mem_item_t mem_q[$];
  ack_item_t ack_q[$];

  int n_vec = 0;
  int n_err = 0;
  int cpu_acks = 0, host_acks = 0, cs_cnt = 0, we_cnt = 0;
  int cs_cyc = 0, ack_cyc = 0;

  logic [DW-1:0] ref_mem [256];
  bit            ref_vld [256];
  logic [DW-1:0] exp_cpu_rd, exp_host_rd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic ref_clear();
    exp_cpu_rd  = '0;
    exp_host_rd = '0;
    for (int i = 0; i < 256; i++) ref_vld[i] = 1'b0;
  endtask

  task automatic exp_access(input bit host, input bit we, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd);
    mem_item_t m;
    ack_item_t k;
    m.we = we; m.addr = a; m.wdata = wd;
    mem_q.push_back(m);
    if (we) begin
      ref_mem[a[7:0]] = wd;
      ref_vld[a[7:0]] = 1'b1;
    end else if (host) begin
      exp_host_rd = ref_vld[a[7:0]] ? ref_mem[a[7:0]] : dflt(a);
    end else begin
      exp_cpu_rd = ref_vld[a[7:0]] ? ref_mem[a[7:0]] : dflt(a);
    end
    k.host  = host;
    k.rdata = host ? exp_host_rd : exp_cpu_rd;
    ack_q.push_back(k);
  endtask

  task automatic set_cpu(input bit req, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = wd;
  endtask

  task automatic set_host(input bit req, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    bus.host_req = req; bus.host_we = we; bus.host_addr = a; bus.host_wdata = wd;
  endtask

  task automatic monitor();
    mem_item_t m;
    ack_item_t k;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (bus.cpu_ack && bus.host_ack) chk("ack_both", {bus.cpu_ack, bus.host_ack}, 2'b01);
        if (bus.mem_we && !bus.mem_cs) chk("we_without_cs", bus.mem_we, 1'b0);
        if (bus.mem_cs) begin
          cs_cnt++;
          cs_cyc = cyc;
          if (bus.mem_we) we_cnt++;
          chk("cs_expected", mem_q.size() != 0, 1'b1);
          if (mem_q.size() != 0) begin
            m = mem_q.pop_front();
            chk("mem_we", bus.mem_we, m.we);
            chk("mem_addr", bus.mem_addr, m.addr);
            if (m.we) chk("mem_wdata", bus.mem_wdata, m.wdata);
          end
        end
        if (bus.cpu_ack || bus.host_ack) begin
          ack_cyc = cyc;
          if (bus.host_ack) host_acks++;
          else              cpu_acks++;
          chk("ack_expected", ack_q.size() != 0, 1'b1);
          if (ack_q.size() != 0) begin
            k = ack_q.pop_front();
            chk("ack_port", bus.host_ack, k.host);
            chk("ack_rdata", bus.host_ack ? bus.host_rdata : bus.cpu_rdata, k.rdata);
          end
        end
      end
    end
  endtask

  task automatic wait_acks(input bit host, input int n, input int maxc);
    int start;
    start = host ? host_acks : cpu_acks;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      #1;
      if ((host ? host_acks : cpu_acks) - start >= n) return;
    end
    chk(host ? "host_ack_timeout" : "cpu_ack_timeout", host ? host_acks : cpu_acks, start + n);
  endtask

  initial begin
    int c0, a0, w0, s0;
    reset = 1'b0;
    bus.cpustate = CS_IDLE;
    set_cpu(0, 0, '0, '0);
    set_host(0, 0, '0, '0);
    ref_clear();
    #2;
    chk("rst_mem_cs", bus.mem_cs, 1'b0);
    chk("rst_mem_we", bus.mem_we, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, '0);
    chk("rst_mem_wdata", bus.mem_wdata, '0);
    chk("rst_cpu_ack", bus.cpu_ack, 1'b0);
    chk("rst_host_ack", bus.host_ack, 1'b0);
    chk("rst_cpu_rdata", bus.cpu_rdata, '0);
    chk("rst_host_rdata", bus.host_rdata, '0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    fork monitor(); join_none

    // CPU read in RUN mode, latency 1 to mem_cs and 2 to ack
    @(posedge clk); #1;
    bus.cpustate = CS_RUN;
    exp_access(0, 0, 16'h0010, '0);
    c0 = cyc;
    set_cpu(1, 0, 16'h0010, '0);
    wait_acks(0, 1, 10);
    chk("lat_cs", cs_cyc, c0 + 1);
    chk("lat_ack", ack_cyc, c0 + 2);
    chk("cpu_rdata_5a", bus.cpu_rdata, 8'h5A);
    @(posedge clk); #1 set_cpu(0, 0, '0, '0);

    // IN mode: host write served, CPU held pending until RUN
    @(posedge clk); #1;
    bus.cpustate = CS_IN;
    exp_access(1, 1, 16'h0003, 8'hC3);
    w0 = we_cnt;
    a0 = cpu_acks;
    set_host(1, 1, 16'h0003, 8'hC3);
    set_cpu(1, 0, 16'h0020, '0);
    wait_acks(1, 1, 10);
    @(posedge clk); #1 set_host(0, 0, '0, '0);
    repeat (6) @(posedge clk);
    #1;
    chk("cpu_pending_no_ack", cpu_acks, a0);
    chk("host_one_write", we_cnt, w0 + 1);
    exp_access(0, 0, 16'h0020, '0);
    bus.cpustate = CS_RUN;
    wait_acks(0, 1, 10);
    @(posedge clk); #1 set_cpu(0, 0, '0, '0);

    // idle mode: nothing granted for 10 cycles
    @(posedge clk); #1;
    bus.cpustate = CS_IDLE;
    s0 = cs_cnt;
    a0 = cpu_acks + host_acks;
    set_cpu(1, 0, 16'h0011, '0);
    set_host(1, 1, 16'h0012, 8'h77);
    repeat (10) @(posedge clk);
    #1;
    chk("idle_no_cs", cs_cnt, s0);
    chk("idle_no_ack", cpu_acks + host_acks, a0);
    set_cpu(0, 0, '0, '0);
    set_host(0, 0, '0, '0);

    // reset in the middle of a CPU access
    @(posedge clk); #1;
    bus.cpustate = CS_RUN;
    set_cpu(1, 0, 16'h0030, '0);
    @(posedge clk); #1;
    chk("acc_cs_before_rst", bus.mem_cs, 1'b1);
    #1 reset = 1'b0;
    #1;
    chk("midrst_mem_cs", bus.mem_cs, 1'b0);
    chk("midrst_mem_we", bus.mem_we, 1'b0);
    chk("midrst_mem_addr", bus.mem_addr, '0);
    chk("midrst_cpu_ack", bus.cpu_ack, 1'b0);
    chk("midrst_cpu_rdata", bus.cpu_rdata, '0);
    set_cpu(0, 0, '0, '0);
    ref_clear();
    a0 = cpu_acks;
    @(posedge clk); #3 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_dropped", cpu_acks, a0);
    exp_access(0, 0, 16'h0030, '0);
    c0 = cyc;
    set_cpu(1, 0, 16'h0030, '0);
    wait_acks(0, 1, 10);
    chk("rerq_lat_ack", ack_cyc, c0 + 2);
    @(posedge clk); #1 set_cpu(0, 0, '0, '0);

    // mode change RUN->IN during ACC_CPU: CPU completes, host next
    @(posedge clk); #1;
    exp_access(0, 0, 16'h0044, '0);
    exp_access(1, 0, 16'h0055, '0);
    set_cpu(1, 0, 16'h0044, '0);
    set_host(1, 0, 16'h0055, '0);
    @(posedge clk); #1;
    bus.cpustate = CS_IN;
    wait_acks(0, 1, 10);
    @(posedge clk); #1 set_cpu(0, 0, '0, '0);
    wait_acks(1, 1, 10);
    @(posedge clk); #1 set_host(0, 0, '0, '0);

    // CHECK mode with both ports requesting continuously
    @(posedge clk); #1 reset = 1'b0;
    ref_clear();
    @(posedge clk); #3 reset = 1'b1;
    @(posedge clk); #1;
    bus.cpustate = CS_CHECK;
`ifdef MEM_ARB_RR_EN
    exp_access(1, 0, 16'h0060, '0);
    exp_access(0, 0, 16'h0061, '0);
    exp_access(1, 0, 16'h0060, '0);
    exp_access(0, 0, 16'h0061, '0);
    a0 = cpu_acks + host_acks;
    set_host(1, 0, 16'h0060, '0);
    set_cpu(1, 0, 16'h0061, '0);
    begin
      int done;
      done = 0;
      for (int i = 0; i < 40 && done == 0; i++) begin
        @(negedge clk); #1;
        if (cpu_acks + host_acks - a0 >= 4) done = 1;
      end
      chk("rr_four_acks", cpu_acks + host_acks, a0 + 4);
    end
`else
    exp_access(1, 0, 16'h0060, '0);
    exp_access(1, 0, 16'h0060, '0);
    a0 = cpu_acks;
    set_host(1, 0, 16'h0060, '0);
    set_cpu(1, 0, 16'h0061, '0);
    wait_acks(1, 2, 20);
    chk("check_cpu_excluded", cpu_acks, a0);
`endif
    @(posedge clk); #1;
    set_cpu(0, 0, '0, '0);
    set_host(0, 0, '0, '0);

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", mem_q.size() + ack_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
